// File: rtl/tanimoto_pkg.sv
// Shared sizing and FSM state type for the Tanimoto accelerator threshold path.
// The threshold table holds VECTOR_WIDTH+1 entries, one per possible popcount.
package tanimoto_pkg;

  localparam int VECTOR_WIDTH = 920;
  localparam int CNT_WIDTH    = $clog2(VECTOR_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD,
    RUN
  } cfg_state_e;

endpackage

// File: rtl/axis_handshake_gate.sv
// Combinational AXI4-Stream valid/ready gate; a single enable opens both directions.
module axis_handshake_gate (
  input  logic en,
  input  logic s_tvalid,
  output logic s_tready,
  output logic m_tvalid,
  input  logic m_tready
);

  assign m_tvalid = s_tvalid & en;
  assign s_tready = m_tready & en;

endmodule

// File: rtl/threshold_cfg_ctrl.sv
// Loads the popcount threshold table from an AXI4-Stream into BRAM port A and
// gates the vector stream so vectors only flow while the table is valid.
module threshold_cfg_ctrl #(
  parameter int VECTOR_WIDTH = tanimoto_pkg::VECTOR_WIDTH,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 acc_idle,
  input  logic [CNT_WIDTH:0]   s_cfg_tdata,
  input  logic                 s_cfg_tvalid,
  input  logic                 s_cfg_tlast,
  output logic                 s_cfg_tready,
  output logic [CNT_WIDTH-1:0] bram_addr,
  output logic [CNT_WIDTH:0]   bram_wrdata,
  output logic                 bram_en,
  output logic                 bram_we,
  input  logic                 s_vec_tvalid,
  output logic                 s_vec_tready,
  output logic                 m_vec_tvalid,
  input  logic                 m_vec_tready,
  output logic                 cfg_done,
  output logic                 cfg_err
);

  import tanimoto_pkg::*;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(VECTOR_WIDTH);

  cfg_state_e           state;
  cfg_state_e           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 beat_acc;
  logic                 last_beat;
  logic                 bad_beat;
  logic                 good_end;
  logic                 run_en;
  logic                 start_acc;

  assign s_cfg_tready = (state == LOAD);
  assign beat_acc     = s_cfg_tvalid & s_cfg_tready;
  assign last_beat    = (cnt == LAST_BEAT);
  // tlast must coincide exactly with the final popcount entry
  assign bad_beat     = beat_acc & (s_cfg_tlast ^ last_beat);
  assign good_end     = beat_acc & s_cfg_tlast & last_beat;
  assign run_en       = (state == RUN);
  assign start_acc    = start & ((state == IDLE) | (state == RUN));
  assign cfg_done     = run_en;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      RUN:     if (start) state_nxt = DRAIN;
      DRAIN:   if (acc_idle) state_nxt = LOAD;
      LOAD: begin
        if (good_end)      state_nxt = RUN;
        else if (bad_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cfg_err     <= 1'b0;
      bram_en     <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
    end else begin
      state   <= state_nxt;
      bram_en <= beat_acc;
      bram_we <= beat_acc;
      if (beat_acc) begin
        bram_addr   <= cnt;
        bram_wrdata <= s_cfg_tdata;
      end
      if ((state != LOAD) && (state_nxt == LOAD))
        cnt <= '0;
      else if (beat_acc)
        cnt <= cnt + CNT_WIDTH'(1);
      if (bad_beat)
        cfg_err <= 1'b1;
      else if (start_acc)
        cfg_err <= 1'b0;
    end
  end

  // Vector beats flow only while the table is valid; a beat in the start cycle still completes
  axis_handshake_gate u_vec_gate (
    .en       (run_en),
    .s_tvalid (s_vec_tvalid),
    .s_tready (s_vec_tready),
    .m_tvalid (m_vec_tvalid),
    .m_tready (m_vec_tready)
  );

endmodule

// File: tb/tb_threshold_cfg_ctrl.sv
// Randomized bench for threshold_cfg_ctrl: transaction-level model of the table
// load (expected write list per load) plus direct checks of the vector gate.
module tb_threshold_cfg_ctrl;

  localparam int VW = 920;
  localparam int CW = $clog2(VW);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          acc_idle;
  logic [CW:0]   s_cfg_tdata;
  logic          s_cfg_tvalid;
  logic          s_cfg_tlast;
  logic          s_cfg_tready;
  logic [CW-1:0] bram_addr;
  logic [CW:0]   bram_wrdata;
  logic          bram_en;
  logic          bram_we;
  logic          s_vec_tvalid;
  logic          s_vec_tready;
  logic          m_vec_tvalid;
  logic          m_vec_tready;
  logic          cfg_done;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];

  threshold_cfg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .acc_idle     (acc_idle),
    .s_cfg_tdata  (s_cfg_tdata),
    .s_cfg_tvalid (s_cfg_tvalid),
    .s_cfg_tlast  (s_cfg_tlast),
    .s_cfg_tready (s_cfg_tready),
    .bram_addr    (bram_addr),
    .bram_wrdata  (bram_wrdata),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .s_vec_tvalid (s_vec_tvalid),
    .s_vec_tready (s_vec_tready),
    .m_vec_tvalid (m_vec_tvalid),
    .m_vec_tready (m_vec_tready),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input logic en, input logic we,
                                       input logic [15:0] addr, input logic [15:0] data);
    logic [63:0] r;
    r = '0;
    r[63] = en;
    r[62] = we;
    r[47:32] = addr;
    r[15:0] = data;
    return r;
  endfunction

  always @(negedge clk)
    if (bram_en || bram_we)
      act_q.push_back(pack(bram_en, bram_we, 16'(bram_addr), 16'(bram_wrdata)));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_wr"}, act_q[i], exp_q[i]);
  endtask

  // Send n beats (data k+1 or random), tlast on beat last_idx (-1: none).
  // Builds the expected write list from the load rules before sending.
  task automatic run_load(input int n, input int last_idx, input bit gaps,
                          input bit rnd, output bit exp_err, output int cycles);
    logic [CW:0] d[];
    bit          tl[];
    bit          term;
    int          k;
    int          guard;
    d  = new[n];
    tl = new[n];
    for (int i = 0; i < n; i++) begin
      d[i]  = rnd ? (CW+1)'($urandom) : (CW+1)'(i + 1);
      tl[i] = (i == last_idx);
    end
    exp_q.delete();
    act_q.delete();
    term = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < n && !term; i++) begin
      exp_q.push_back(pack(1'b1, 1'b1, 16'(i), 16'(d[i])));
      if (tl[i] || i == VW) begin
        term = 1'b1;
        exp_err = !(tl[i] && i == VW);
      end
    end
    k = 0;
    cycles = 0;
    guard = 0;
    while (k < n && guard < 4 * n + 100) begin
      @(negedge clk);
      guard++;
      s_cfg_tvalid = gaps ? ((guard % 2) == 1) : 1'b1;
      s_cfg_tdata  = d[k];
      s_cfg_tlast  = tl[k];
      #1;
      cycles++;
      if (s_cfg_tvalid && s_cfg_tready) k++;
    end
    if (k < n) chk("load_timeout", 64'(k), 64'(n));
    chk("done_during_load", 64'(cfg_done), 64'd0);
  endtask

  task automatic finish_load(input string tag, input bit exp_err);
    @(negedge clk);
    s_cfg_tvalid = 1'b0;
    s_cfg_tlast  = 1'b0;
    #1;
    chk({tag, "_done"}, 64'(cfg_done), 64'(!exp_err));
    chk({tag, "_err"}, 64'(cfg_err), 64'(exp_err));
    chk({tag, "_tready_off"}, 64'(s_cfg_tready), 64'd0);
    repeat (2) @(negedge clk);
    compare_writes(tag);
  endtask

  task automatic pulse_start(input bit idle);
    @(negedge clk);
    start = 1'b1;
    acc_idle = idle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic gate_random(input string tag, input int n);
    bit sv, mr;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sv = 1'($urandom);
      mr = 1'($urandom);
      s_vec_tvalid = sv;
      m_vec_tready = mr;
      #1;
      chk({tag, "_mvalid"}, 64'(m_vec_tvalid), 64'(sv));
      chk({tag, "_sready"}, 64'(s_vec_tready), 64'(mr));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    int cyc;
    int idx;
    rst = 1'b1;
    start = 1'b0;
    acc_idle = 1'b1;
    s_cfg_tdata = '0;
    s_cfg_tvalid = 1'b0;
    s_cfg_tlast = 1'b0;
    s_vec_tvalid = 1'b1;
    m_vec_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", 64'(cfg_done), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    chk("rst_cfg_tready", 64'(s_cfg_tready), 64'd0);
    chk("rst_bram", pack(bram_en, bram_we, 16'(bram_addr), 16'(bram_wrdata)), 64'd0);
    chk("rst_vec_gate", 64'({s_vec_tready, m_vec_tvalid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full back-to-back load
    pulse_start(1'b1);
    #1;
    chk("idle_to_load", 64'(s_cfg_tready), 64'd1);
    run_load(VW + 1, VW, 1'b0, 1'b0, e, cyc);
    chk("b2b_cycles", 64'(cyc), 64'(VW + 1));
    finish_load("b2b", e);

    gate_random("gate", 12);
    @(negedge clk);
    s_vec_tvalid = 1'b1;
    m_vec_tready = 1'b0;
    #1;
    chk("gate_mready0_sready", 64'(s_vec_tready), 64'd0);
    chk("gate_mready0_mvalid", 64'(m_vec_tvalid), 64'd1);

    // Reload from RUN while the accelerator is busy
    @(negedge clk);
    start = 1'b1;
    acc_idle = 1'b0;
    m_vec_tready = 1'b1;
    #1;
    chk("start_cycle_handshake", 64'({m_vec_tvalid, s_vec_tready}), 64'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      #1;
      chk("drain_gate", 64'({s_vec_tready, m_vec_tvalid, s_cfg_tready, cfg_done}), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    acc_idle = 1'b1;
    #1;
    chk("drain_hold", 64'(s_cfg_tready), 64'd0);
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("drain_to_load", 64'(s_cfg_tready), 64'd1);
    run_load(VW + 1, VW, 1'b1, 1'b1, e, cyc);
    start = 1'b0;
    finish_load("toggle", e);

    // DRAIN with acc_idle already high lasts one cycle, then early tlast on beat 5
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("drain_one_cycle_a", 64'(s_cfg_tready), 64'd0);
    @(negedge clk);
    #1;
    chk("drain_one_cycle_b", 64'(s_cfg_tready), 64'd1);
    run_load(6, 5, 1'b0, 1'b0, e, cyc);
    finish_load("early5", e);
    chk("early5_vec_closed", 64'(s_vec_tready), 64'd0);

    act_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_cfg_tvalid = 1'b1;
      s_cfg_tlast = 1'b1;
    end
    @(negedge clk);
    s_cfg_tvalid = 1'b0;
    s_cfg_tlast = 1'b0;
    repeat (2) @(negedge clk);
    compare_writes("idle_ignores_beats");

    pulse_start(1'b1);
    #1;
    chk("err_cleared", 64'(cfg_err), 64'd0);
    idx = $urandom_range(VW - 1, 0);
    run_load(idx + 1, idx, 1'($urandom), 1'b1, e, cyc);
    finish_load("early_rnd", e);

    // Missing tlast on the final beat
    pulse_start(1'b1);
    run_load(VW + 1, -1, 1'b0, 1'b1, e, cyc);
    finish_load("no_tlast", e);

    // Reset in the middle of a load
    pulse_start(1'b1);
    #1;
    chk("err_cleared2", 64'(cfg_err), 64'd0);
    run_load(401, -1, 1'b0, 1'b0, e, cyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_bram", pack(bram_en, bram_we, 16'(bram_addr), 16'(bram_wrdata)), 64'd0);
    chk("midrst_ctrl", 64'({cfg_done, cfg_err, s_cfg_tready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_after", 64'({cfg_done, s_cfg_tready, bram_en}), 64'd0);
    s_cfg_tvalid = 1'b0;
    @(negedge clk);
    compare_writes("midrst");

    // A fresh start reloads from address 0
    pulse_start(1'b1);
    run_load(3, 2, 1'b0, 1'b1, e, cyc);
    finish_load("restart", e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
